if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID stage register. It owns the PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It buffers the returned word and presents pc_plus4/instruction with a valid flag to IF/ID. It also honours hazard stalls (pc_write) and branch/jump redirects, discarding any in-flight or buffered wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0
NOP_INSTR, 32'h0000_0000, word driven on instruction_out when fetch_valid=0

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
pc_write  in  1  from hazard unit; 1 = IF/ID accepts this cycle (same net as IF/ID write enable)
redirect_valid  in  1  one-cycle pulse, taken branch/jump resolved
redirect_target  in  32  new PC; bits [1:0] ignored, forced to 0
imem_req  out  1  request valid
imem_addr  out  32  word-aligned fetch address, stable while imem_req=1
imem_gnt  in  1  request accepted this cycle when imem_req=1
imem_rvalid  in  1  read data valid; asserted at least 1 cycle after gnt, exactly once per grant
imem_rdata  in  32  instruction word
pc_out  out  32  current PC, for debug and branch-target use
pc_plus4_out  out  32  PC of buffered instruction + 4; 0 when fetch_valid=0
instruction_out  out  32  buffered instruction; NOP_INSTR when fetch_valid=0
fetch_valid  out  1  instruction_out holds a correct-path instruction

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, buffer=0, fetch_valid=0, imem_req=0 while reset is high, pc_plus4_out=0, instruction_out=NOP_INSTR.
- States: FETCH, WAIT, VALID, DROP. Exactly one outstanding imem request at any time.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On gnt, go to WAIT.
- WAIT:
  - imem_req=0.
  - On rvalid, buffer<=rdata, bufpc<=pc, go to VALID.
- VALID:
  - fetch_valid=1; outputs driven from the buffer.
  - When pc_write=1: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), go to FETCH.
  - When pc_write=0: hold everything.
- DROP:
  - imem_req=0.
  - On rvalid, discard data and go to FETCH.
- Redirect has priority over pc_write and over any state action. pc<={redirect_target[31:2],2'b00} in every state.
  - In FETCH without gnt this cycle: stay in FETCH; the next request uses the new pc.
  - In FETCH with gnt this cycle: the old-pc request is in flight, go to DROP.
  - In WAIT without rvalid: go to DROP.
  - In WAIT with rvalid: discard the data, go to FETCH.
  - In VALID: discard the buffer, fetch_valid drops next cycle, go to FETCH.
  - In DROP: update pc, stay in DROP. If rvalid arrives the same cycle, go to FETCH.
- pc_write is ignored outside VALID. IF/ID captures NOP/0 bubbles in those cycles.
- Best-case throughput: 1 instruction per 3 cycles (gnt, rvalid, accept).
- Outputs are registered except imem_req and imem_addr, which are decoded from state and pc.
- pc_out is always the registered pc.
- rvalid in FETCH or VALID is a protocol error; it is ignored.

Decomposition:
- Shared package holds the state encoding enum (FETCH, WAIT, VALID, DROP), the NOP_INSTR constant, and the PC increment constant 32'd4.
- One natural sub-module: if_pc_reg. It holds the PC register with async reset to RESET_PC, a redirect mux, +4 increment and target alignment.
- The FSM and the instruction buffer stay in the top module.

Test Plan:
1. Reset released, imem_gnt=1 always, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000, pc_write=1 -> imem_addr sequence 0,4,8. fetch_valid pulses every 3rd cycle with pc_plus4_out 4,8,12 and matching instruction_out.
2. In VALID with instr 32'h8C22_0004, hold pc_write=0 for 5 cycles -> outputs frozen, fetch_valid=1, no imem_req. Then pc_write=1 -> next imem_addr = pc+4.
3. redirect_valid with target 32'h0000_0103 while in WAIT, rvalid 3 cycles later -> that data is discarded, fetch_valid stays 0, next imem_addr=32'h0000_0100.
4. redirect_valid in FETCH in the same cycle as gnt for addr 32'h10 -> DROP. The response is discarded, then a request is issued to the target.
5. pc=32'hFFFF_FFFC fetched and accepted -> next imem_addr=32'h0000_0000, and pc_plus4_out of that instruction=32'h0000_0000.
6. Assert reset mid-WAIT -> outputs clear immediately (asynchronously). After release, the first request is to RESET_PC, and a late rvalid from before reset is ignored.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// PC register: async reset to RESET_PC, redirect has priority over +4.
module if_pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc
);

    logic [31:0] target_aligned;
    logic [31:0] pc_next;

    // Low two bits of the target are dropped so the PC stays word aligned.
    assign target_aligned = redirect_target & ~32'd3;

    // Next-PC select: redirect wins, otherwise advance when the stage retires.
    always_comb begin
        pc_next = pc;
        if (redirect_valid)
            pc_next = target_aligned;
        else if (inc)
            pc_next = pc + PC_INC;
    end

    // PC state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_PC & ~32'd3;
        else
            pc <= pc_next;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request, single-entry buffer,
// hazard stall and redirect handling with wrong-path squash.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
);

    fetch_state_t state, state_next;
    logic         inc;
    logic         load;
    logic         clear;
    logic [31:0]  pc;

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk             (clk),
        .reset           (reset),
        .inc             (inc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc)
    );

    assign pc_out    = pc;
    assign imem_addr = pc;
    // Request is decoded from state; held low while reset is asserted.
    assign imem_req  = (state == FETCH) && !reset;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    // Next state plus buffer load/clear and PC advance strobes.
    always_comb begin
        state_next = state;
        inc        = 1'b0;
        load       = 1'b0;
        clear      = 1'b0;
        case (state)
            FETCH: begin
                if (imem_gnt)
                    state_next = redirect_valid ? DROP : WAIT;
            end
            WAIT: begin
                if (redirect_valid)
                    state_next = imem_rvalid ? FETCH : DROP;
                else if (imem_rvalid) begin
                    state_next = VALID;
                    load       = 1'b1;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    state_next = FETCH;
                    clear      = 1'b1;
                end else if (pc_write) begin
                    state_next = FETCH;
                    inc        = 1'b1;
                    clear      = 1'b1;
                end
            end
            DROP: begin
                // In-flight wrong-path response: wait for it and throw it away.
                if (imem_rvalid)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Instruction buffer, which directly drives the IF/ID-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid     <= 1'b0;
            pc_plus4_out    <= 32'd0;
            instruction_out <= NOP_INSTR;
        end else if (load) begin
            fetch_valid     <= 1'b1;
            pc_plus4_out    <= pc + PC_INC;
            instruction_out <= imem_rdata;
        end else if (clear) begin
            fetch_valid     <= 1'b0;
            pc_plus4_out    <= 32'd0;
            instruction_out <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit.
module tb_if_fetch_unit;

    localparam logic [31:0] N = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        pw;
        logic        red;
        logic [31:0] tgt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [44];

    if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_write        (pc_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .pc_plus4_out    (pc_plus4_out),
        .instruction_out (instruction_out),
        .fetch_valid     (fetch_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic pw, logic red, logic [31:0] tgt, logic gnt,
                                logic rv, logic [31:0] rdata, logic e_req,
                                logic [31:0] e_addr, logic e_fv, logic [31:0] e_pc4,
                                logic [31:0] e_instr, logic [31:0] e_pc);
        vec_t v;
        v.pw = pw; v.red = red; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv; v.e_pc4 = e_pc4;
        v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        pc_write = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    endtask

    // Drive one cycle's inputs at negedge, check outputs 1 time unit later.
    task automatic step(input int i);
        @(negedge clk);
        pc_write        = tbl[i].pw;
        redirect_valid  = tbl[i].red;
        redirect_target = tbl[i].tgt;
        imem_gnt        = tbl[i].gnt;
        imem_rvalid     = tbl[i].rv;
        imem_rdata      = tbl[i].rdata;
        #1;
        chk($sformatf("row%0d req", i),   {31'd0, imem_req},    {31'd0, tbl[i].e_req});
        if (tbl[i].e_req)
            chk($sformatf("row%0d addr", i), imem_addr,         tbl[i].e_addr);
        chk($sformatf("row%0d fv", i),    {31'd0, fetch_valid}, {31'd0, tbl[i].e_fv});
        chk($sformatf("row%0d pc4", i),   pc_plus4_out,         tbl[i].e_pc4);
        chk($sformatf("row%0d instr", i), instruction_out,      tbl[i].e_instr);
        chk($sformatf("row%0d pc", i),    pc_out,               tbl[i].e_pc);
    endtask

    initial begin
        // Sequential fetch, rdata = addr ^ A5A5_0000
        tbl[0]  = mk(1,0,0,1,0,0,                 1,0,  0,0,N,0);
        tbl[1]  = mk(1,0,0,1,1,32'hA5A5_0000,     0,0,  0,0,N,0);
        tbl[2]  = mk(1,0,0,1,0,0,                 0,0,  1,4,32'hA5A5_0000,0);
        tbl[3]  = mk(1,0,0,1,0,0,                 1,4,  0,0,N,4);
        tbl[4]  = mk(1,0,0,1,1,32'hA5A5_0004,     0,0,  0,0,N,4);
        tbl[5]  = mk(1,0,0,1,0,0,                 0,0,  1,8,32'hA5A5_0004,4);
        tbl[6]  = mk(1,0,0,1,0,0,                 1,8,  0,0,N,8);
        tbl[7]  = mk(1,0,0,1,1,32'hA5A5_0008,     0,0,  0,0,N,8);
        tbl[8]  = mk(1,0,0,1,0,0,                 0,0,  1,12,32'hA5A5_0008,8);
        // Stall in VALID for 5 cycles, then accept
        tbl[9]  = mk(1,0,0,1,0,0,                 1,12, 0,0,N,12);
        tbl[10] = mk(0,0,0,1,1,32'h8C22_0004,     0,0,  0,0,N,12);
        for (int k = 11; k <= 15; k++)
            tbl[k] = mk(0,0,0,1,0,0,              0,0,  1,16,32'h8C22_0004,12);
        tbl[16] = mk(1,0,0,1,0,0,                 0,0,  1,16,32'h8C22_0004,12);
        tbl[17] = mk(1,0,0,1,0,0,                 1,16, 0,0,N,16);
        // Redirect in WAIT (target 0x103), late response dropped
        tbl[18] = mk(1,1,32'h103,0,0,0,           0,0,  0,0,N,16);
        tbl[19] = mk(1,0,0,0,0,0,                 0,0,  0,0,N,32'h100);
        tbl[20] = mk(1,0,0,0,0,0,                 0,0,  0,0,N,32'h100);
        tbl[21] = mk(1,0,0,0,1,32'hDEAD_BEEF,     0,0,  0,0,N,32'h100);
        // Redirect in FETCH without gnt, then with gnt for addr 0x10
        tbl[22] = mk(0,1,32'h10,0,0,0,            1,32'h100, 0,0,N,32'h100);
        tbl[23] = mk(0,1,32'h40,1,0,0,            1,32'h10,  0,0,N,32'h10);
        tbl[24] = mk(0,0,0,0,1,32'h1111_1111,     0,0,  0,0,N,32'h40);
        tbl[25] = mk(0,0,0,1,0,0,                 1,32'h40, 0,0,N,32'h40);
        tbl[26] = mk(0,0,0,0,1,32'h2222_2222,     0,0,  0,0,N,32'h40);
        tbl[27] = mk(1,0,0,0,0,0,                 0,0,  1,32'h44,32'h2222_2222,32'h40);
        // PC wrap at top of address space
        tbl[28] = mk(0,1,32'hFFFF_FFFF,0,0,0,     1,32'h44, 0,0,N,32'h44);
        tbl[29] = mk(0,0,0,1,0,0,                 1,32'hFFFF_FFFC, 0,0,N,32'hFFFF_FFFC);
        tbl[30] = mk(0,0,0,0,1,32'h3333_3333,     0,0,  0,0,N,32'hFFFF_FFFC);
        tbl[31] = mk(1,0,0,0,0,0,                 0,0,  1,0,32'h3333_3333,32'hFFFF_FFFC);
        tbl[32] = mk(0,0,0,0,0,0,                 1,0,  0,0,N,0);
        // Redirect in VALID, then redirect in WAIT coincident with rvalid
        tbl[33] = mk(0,0,0,1,0,0,                 1,0,  0,0,N,0);
        tbl[34] = mk(0,0,0,0,1,32'h4444_4444,     0,0,  0,0,N,0);
        tbl[35] = mk(0,1,32'h200,0,0,0,           0,0,  1,4,32'h4444_4444,0);
        tbl[36] = mk(0,0,0,1,0,0,                 1,32'h200, 0,0,N,32'h200);
        tbl[37] = mk(0,1,32'h300,0,1,32'h5555_5555, 0,0, 0,0,N,32'h200);
        tbl[38] = mk(0,0,0,1,0,0,                 1,32'h300, 0,0,N,32'h300);
        tbl[39] = mk(0,0,0,0,0,0,                 0,0,  0,0,N,32'h300);
        // After mid-WAIT reset: stale rvalid ignored, then normal fetch
        tbl[40] = mk(0,0,0,0,1,32'h7777_7777,     1,0,  0,0,N,0);
        tbl[41] = mk(0,0,0,1,0,0,                 1,0,  0,0,N,0);
        tbl[42] = mk(0,0,0,0,1,32'h6666_6666,     0,0,  0,0,N,0);
        tbl[43] = mk(0,0,0,0,0,0,                 0,0,  1,4,32'h6666_6666,0);

        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req",   {31'd0, imem_req},    32'd0);
        chk("reset fv",    {31'd0, fetch_valid}, 32'd0);
        chk("reset pc4",   pc_plus4_out,         32'd0);
        chk("reset instr", instruction_out,      N);
        chk("reset pc",    pc_out,               32'd0);
        reset = 1'b0;

        for (int i = 0; i < 44; i++) begin
            if (i == 40) begin
                // Async reset asserted mid-WAIT, between clock edges
                @(negedge clk);
                idle();
                #2;
                reset = 1'b1;
                #1;
                chk("async req",   {31'd0, imem_req},    32'd0);
                chk("async fv",    {31'd0, fetch_valid}, 32'd0);
                chk("async pc",    pc_out,               32'd0);
                chk("async instr", instruction_out,      N);
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
            end
            step(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
